profile_counter_ctrl: RTL and testbench

Bus-side controller and reader for the profiling counters. Holds NUM_COUNTERS event counters, and the CPU starts, stops, clears and snapshots them through memory-mapped registers on a request/acknowledge bus. It sits between the processor's peripheral bus and the event sources being profiled (cycles, stalls, bus-idle, user events), and returns atomically captured counter values to software.

---
 rtl/profile_counter_pkg.sv | 22 ++
 rtl/profile_counter_ctrl_if.sv | 25 ++
 rtl/prof_cnt_slot.sv | 42 ++++
 rtl/profile_counter_ctrl.sv | 109 ++++++++++
 tb/tb_profile_counter_ctrl.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/profile_counter_pkg.sv
// Shared constants for the profiling counter block: register map, control
// field positions and bus FSM states.
package profile_counter_pkg;

  localparam int unsigned MAX_COUNTERS = 4;

  localparam logic [5:0] CTRL        = 6'h00;
  localparam logic [5:0] STATUS      = 6'h04;
  localparam logic [5:0] SHADOW_BASE = 6'h10;
  localparam logic [5:0] LIVE_BASE   = 6'h20;

  localparam int unsigned START_LSB = 0;
  localparam int unsigned STOP_LSB  = 4;
  localparam int unsigned CLEAR_LSB = 8;
  localparam int unsigned SNAP_BIT  = 12;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } bus_state_e;

endpackage

// File: rtl/profile_counter_ctrl_if.sv
// Request/acknowledge peripheral bus between the CPU side and the profiling
// counter controller.
interface profile_counter_ctrl_if;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 32;

  logic              busRequest;
  logic              busWrite;
  logic [ADDR_W-1:0] busAddress;
  logic [DATA_W-1:0] busWriteData;
  logic [DATA_W-1:0] busReadData;
  logic              busAck;

  modport master (
    output busRequest, busWrite, busAddress, busWriteData,
    input  busReadData, busAck
  );

  modport slave (
    input  busRequest, busWrite, busAddress, busWriteData,
    output busReadData, busAck
  );

endinterface

// File: rtl/prof_cnt_slot.sv
// One profiling counter with sticky wrap flag and snapshot shadow register.
// Clear dominates increment and wrap; snapshot captures the pre-edge value.
module prof_cnt_slot #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_run,
  input  logic             i_event,
  input  logic             i_clear,
  input  logic             i_snap,
  output logic [WIDTH-1:0] o_live,
  output logic [WIDTH-1:0] o_shadow,
  output logic             o_overflow
);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_shadow;
  logic             r_overflow;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_count    <= '0;
      r_shadow   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (i_snap) r_shadow <= r_count;
      if (i_clear) begin
        r_count    <= '0;
        r_overflow <= 1'b0;
      end else if (i_run && i_event) begin
        r_count <= r_count + WIDTH'(1);
        if (&r_count) r_overflow <= 1'b1;
      end
    end
  end

  assign o_live     = r_count;
  assign o_shadow   = r_shadow;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/profile_counter_ctrl.sv
// Profiling counter controller: bus handshake FSM, register decode, running
// mask, per-counter slots and the registered read mux / overflow interrupt.
module profile_counter_ctrl
  import profile_counter_pkg::*;
#(
  parameter int unsigned NUM_COUNTERS = 4,
  parameter int unsigned WIDTH        = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_COUNTERS-1:0] eventIn,
  profile_counter_ctrl_if.slave   bus,
  output logic                    overflowIrq
);

  bus_state_e              r_state;
  bus_state_e              w_state_next;
  logic                    w_accept;
  logic                    w_ctrl_wr;
  logic                    w_snap;
  logic [5:0]              w_addr;
  logic [NUM_COUNTERS-1:0] r_running;
  logic [NUM_COUNTERS-1:0] w_start;
  logic [NUM_COUNTERS-1:0] w_stop;
  logic [NUM_COUNTERS-1:0] w_clear;
  logic [NUM_COUNTERS-1:0] w_overflow;
  logic [WIDTH-1:0]        w_live   [NUM_COUNTERS];
  logic [WIDTH-1:0]        w_shadow [NUM_COUNTERS];
  logic [31:0]             w_rdata;
  logic [31:0]             r_rdata;
  logic                    r_irq;
  logic                    w_unused;

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Requests are only accepted from IDLE, so the ack cycle blocks a new one.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.busRequest) begin
          w_accept     = 1'b1;
          w_state_next = S_ACK;
        end
      end
      S_ACK:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_addr    = {bus.busAddress[5:2], 2'b00};
  assign w_ctrl_wr = w_accept & bus.busWrite & (w_addr == CTRL);
  assign w_start   = w_ctrl_wr ? bus.busWriteData[START_LSB +: NUM_COUNTERS] : '0;
  assign w_stop    = w_ctrl_wr ? bus.busWriteData[STOP_LSB  +: NUM_COUNTERS] : '0;
  assign w_clear   = w_ctrl_wr ? bus.busWriteData[CLEAR_LSB +: NUM_COUNTERS] : '0;
  assign w_snap    = w_ctrl_wr & bus.busWriteData[SNAP_BIT];
  assign w_unused  = ^{bus.busAddress[1:0], bus.busWriteData};

  // Stop is applied after start so that a simultaneous request leaves it off.
  always_ff @(posedge clock) begin
    if (reset) r_running <= '0;
    else       r_running <= (r_running | w_start) & ~w_stop;
  end

  for (genvar g = 0; g < NUM_COUNTERS; g++) begin : g_slot
    prof_cnt_slot #(.WIDTH(WIDTH)) u_slot (
      .clock      (clock),
      .reset      (reset),
      .i_run      (r_running[g]),
      .i_event    (eventIn[g]),
      .i_clear    (w_clear[g]),
      .i_snap     (w_snap),
      .o_live     (w_live[g]),
      .o_shadow   (w_shadow[g]),
      .o_overflow (w_overflow[g])
    );
  end

  always_comb begin
    w_rdata = '0;
    if (w_addr == STATUS) begin
      w_rdata[0 +: NUM_COUNTERS]            = r_running;
      w_rdata[MAX_COUNTERS +: NUM_COUNTERS] = w_overflow;
    end
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      if (w_addr == SHADOW_BASE + 6'(4 * i)) w_rdata = 32'(w_shadow[i]);
      if (w_addr == LIVE_BASE   + 6'(4 * i)) w_rdata = 32'(w_live[i]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rdata <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_rdata <= (w_accept && !bus.busWrite) ? w_rdata : '0;
      r_irq   <= |w_overflow;
    end
  end

  assign bus.busAck      = (r_state == S_ACK);
  assign bus.busReadData = r_rdata;
  assign overflowIrq     = r_irq;

endmodule

// File: tb/tb_profile_counter_ctrl.sv
// Bench for profile_counter_ctrl (8-bit counters so wraps are reachable):
// directed scenarios with literal expectations plus a randomized run.
module tb_profile_counter_ctrl;

  localparam int unsigned N    = 4;
  localparam int unsigned MAXV = 255;

  logic         clock = 1'b0;
  logic         reset;
  logic [N-1:0] eventIn;
  logic         overflowIrq;

  logic [N-1:0] ev_fixed;
  bit           ev_rand;
  bit           chk_en;
  int           tests;
  int           fails;

  profile_counter_ctrl_if bus ();

  profile_counter_ctrl #(.NUM_COUNTERS(N), .WIDTH(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .eventIn     (eventIn),
    .bus         (bus),
    .overflowIrq (overflowIrq)
  );

  always #5 clock = ~clock;

  always @(negedge clock) eventIn = ev_rand ? N'($urandom) : ev_fixed;

  // ---------------- behavioural model ----------------
  int unsigned  m_cnt [N];
  int unsigned  m_sh  [N];
  logic [N-1:0] m_run, m_ovf;
  logic         m_ack, m_irq;
  logic [31:0]  m_rd;

  function automatic logic [31:0] model_read(input logic [5:0] a);
    logic [3:0] w;
    w = a[5:2];
    if (w == 4'd1) return {24'd0, m_ovf, m_run};
    if (w >= 4'd4 && w <= 4'd7) return m_sh[w - 4'd4];
    if (w >= 4'd8 && w <= 4'd11) return m_cnt[w - 4'd8];
    return 32'd0;
  endfunction

  always @(posedge clock) begin
    logic        acc, cw, sn;
    logic [31:0] wd;
    logic [N-1:0] st, sp, cl;
    if (reset) begin
      for (int i = 0; i < N; i++) begin m_cnt[i] = 0; m_sh[i] = 0; end
      m_run = '0; m_ovf = '0; m_ack = 1'b0; m_irq = 1'b0; m_rd = '0;
    end else begin
      acc = bus.busRequest && !m_ack;
      cw  = acc && bus.busWrite && (bus.busAddress[5:2] == 4'd0);
      wd  = bus.busWriteData;
      st  = cw ? wd[3:0]  : '0;
      sp  = cw ? wd[7:4]  : '0;
      cl  = cw ? wd[11:8] : '0;
      sn  = cw && wd[12];
      m_rd  = (acc && !bus.busWrite) ? model_read(bus.busAddress) : 32'd0;
      m_ack = acc;
      m_irq = (m_ovf != '0);
      for (int i = 0; i < N; i++) begin
        if (sn) m_sh[i] = m_cnt[i];
        if (cl[i]) begin
          m_cnt[i] = 0;
          m_ovf[i] = 1'b0;
        end else if (m_run[i] && eventIn[i]) begin
          if (m_cnt[i] == MAXV) begin
            m_cnt[i] = 0;
            m_ovf[i] = 1'b1;
          end else begin
            m_cnt[i] = m_cnt[i] + 1;
          end
        end
      end
      m_run = (m_run | st) & ~sp;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      chk("busAck", 32'(bus.busAck), 32'(m_ack));
      if (m_ack) chk("busReadData", bus.busReadData, m_rd);
      chk("overflowIrq", 32'(overflowIrq), 32'(m_irq));
    end
  end

  // ---------------- bus tasks ----------------
  task automatic bus_txn(input bit wr, input logic [5:0] a, input logic [31:0] d,
                         output logic [31:0] rd);
    int waits;
    waits = 0;
    @(negedge clock);
    bus.busRequest   = 1'b1;
    bus.busWrite     = wr;
    bus.busAddress   = a;
    bus.busWriteData = d;
    do begin
      @(negedge clock);
      waits++;
    end while (!bus.busAck && waits < 8);
    chk("ack_latency", 32'(waits), 32'd1);
    rd = bus.busReadData;
    bus.busRequest = 1'b0;
    bus.busWrite   = 1'b0;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    logic [31:0] unused_rd;
    bus_txn(1'b1, a, d, unused_rd);
  endtask

  task automatic rd_chk(input string name, input logic [5:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_txn(1'b0, a, 32'd0, d);
    chk(name, d, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] wd;
    logic [5:0]  a;
    logic [3:0]  st, sp, cl;
    tests = 0; fails = 0; chk_en = 1'b0;
    ev_rand = 1'b0; ev_fixed = '0;
    reset = 1'b1;
    bus.busRequest = 1'b0; bus.busWrite = 1'b0;
    bus.busAddress = '0;   bus.busWriteData = '0;
    repeat (2) @(negedge clock);
    chk_en = 1'b1;
    chk("reset_ack", 32'(bus.busAck), 32'd0);
    chk("reset_rdata", bus.busReadData, 32'd0);
    chk("reset_irq", 32'(overflowIrq), 32'd0);
    reset = 1'b0;
    ev_fixed = 4'b0001;

    rd_chk("status_after_reset", 6'h04, 32'd0);
    for (int i = 0; i < N; i++) begin
      rd_chk("shadow_after_reset", 6'(6'h10 + 4 * i), 32'd0);
      rd_chk("live_after_reset",   6'(6'h20 + 4 * i), 32'd0);
    end

    // start0, 10 idle cycles, stop0: 12 enabled edges in total
    wr(6'h00, 32'h001);
    repeat (10) @(negedge clock);
    wr(6'h00, 32'h010);
    rd_chk("live0_count", 6'h20, 32'd12);
    rd_chk("live0_reread", 6'h20, 32'd12);
    chk("model_cnt0_pin", m_cnt[0], 32'd12);

    // bring counter0 to 57, then snapshot+clear+start in one write
    wr(6'h00, 32'h001);
    repeat (43) @(negedge clock);
    wr(6'h00, 32'h010);
    rd_chk("live0_57", 6'h20, 32'd57);
    wr(6'h00, 32'h1101);
    rd_chk("shadow0_snap", 6'h10, 32'd57);
    rd_chk("live0_restart", 6'h20, 32'd3);
    chk("model_sh0_pin", m_sh[0], 32'd57);
    wr(6'h00, 32'h010);

    // counter1 to 255, then one more event wraps it
    ev_fixed = 4'b0010;
    wr(6'h00, 32'h002);
    repeat (253) @(negedge clock);
    wr(6'h00, 32'h020);
    rd_chk("live1_max", 6'h24, 32'd255);
    rd_chk("status_pre_wrap", 6'h04, 32'd0);
    wr(6'h00, 32'h002);
    rd_chk("status_wrap", 6'h04, 32'h22);
    chk("irq_after_wrap", 32'(overflowIrq), 32'd1);
    rd_chk("live1_after_wrap", 6'h24, 32'd2);
    wr(6'h00, 32'h220);
    rd_chk("status_cleared", 6'h04, 32'd0);
    chk("irq_cleared", 32'(overflowIrq), 32'd0);

    // start+stop together leaves counter stopped; stop-all holds values
    ev_fixed = 4'hF;
    wr(6'h00, 32'h001);
    wr(6'h00, 32'h011);
    rd_chk("status_start_stop", 6'h04, 32'd0);
    wr(6'h00, 32'h00F);
    repeat (5) @(negedge clock);
    wr(6'h00, 32'h0F0);
    rd_chk("live0_held", 6'h20, 32'd15);
    rd_chk("live3_held", 6'h2C, 32'd7);
    rd_chk("live0_held_again", 6'h20, 32'd15);

    // continuous request: ack toggles every cycle
    @(negedge clock);
    bus.busRequest = 1'b1; bus.busWrite = 1'b0; bus.busAddress = 6'h04;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      chk("ack_pattern", 32'(bus.busAck), 32'(k % 2));
    end
    bus.busRequest = 1'b0;

    rd_chk("unmapped_3c", 6'h3C, 32'd0);
    rd_chk("ctrl_reads_zero", 6'h00, 32'd0);

    // randomized traffic checked against the model every cycle
    ev_rand = 1'b1;
    for (int t = 0; t < 400; t++) begin
      case ($urandom_range(0, 11))
        0, 1, 2, 3: begin
          st = 4'($urandom);
          sp = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
          cl = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'd0;
          wd = {19'($urandom), 1'($urandom), cl, sp, st};
          wr(6'($urandom_range(0, 3)), wd);
        end
        4: wr(6'($urandom_range(4, 63)), $urandom);
        default: begin
          a = 6'($urandom_range(0, 47));
          bus_txn(1'b0, a, 32'd0, wd);
        end
      endcase
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end

    // reset arriving with a pending request drops it
    ev_rand = 1'b0; ev_fixed = '0;
    @(negedge clock);
    reset = 1'b1;
    bus.busRequest = 1'b1; bus.busWrite = 1'b0; bus.busAddress = 6'h20;
    repeat (2) begin
      @(negedge clock);
      chk("no_ack_in_reset", 32'(bus.busAck), 32'd0);
    end
    bus.busRequest = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    chk("irq_after_reset", 32'(overflowIrq), 32'd0);
    rd_chk("status_after_mid_reset", 6'h04, 32'd0);
    for (int i = 0; i < N; i++) begin
      rd_chk("live_after_mid_reset",   6'(6'h20 + 4 * i), 32'd0);
      rd_chk("shadow_after_mid_reset", 6'(6'h10 + 4 * i), 32'd0);
    end

    repeat (2) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
